adder_byte_sequencer: RTL and testbench
=======================================

Name: adder_byte_sequencer

Overview:
- Sequences one shared 8-bit prefix adder (ripple of carry through its cin/cout pins) to perform NBYTES-wide add/subtract, one byte per cycle, LSB byte first.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Drives the external adder instance's a/b/cin pins and samples its sum/cout; the adder itself lives outside this block.

Parameters:
NBYTES, 4, operand width in bytes; legal range 1..16; W = 8*NBYTES.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operand request
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in for add; ignored when in_sub=1
in_sub  input  1  1 = A - B (B inverted, initial carry 1)
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
out_sum  output  W  result
out_cout  output  1  carry out of MSB byte (for subtract, 1 = no borrow)
out_ovf  output  1  signed two's-complement overflow
add_a  output  8  to shared adder a
add_b  output  8  to shared adder b (already inverted for subtract)
add_cin  output  1  to shared adder cin
add_sum  input  8  from shared adder sum (combinational, same cycle)
add_cout  input  1  from shared adder cout (combinational, same cycle)

Behaviour:
- States: IDLE, RUN, DONE. Reset (any state, mid-operation included) -> IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_ovf=0, out_valid=0; any in-flight operation is discarded.
- Outputs are registered: in_ready=1 iff IDLE; out_valid=1 iff DONE.
- IDLE: on in_valid, capture in_a, b_eff = in_sub ? ~in_b : in_b, carry = in_sub ? 1 : in_cin; set idx=0; go RUN. No capture without in_valid.
- RUN: add_a = a_reg[8*idx +: 8], add_b = b_eff[8*idx +: 8], add_cin = carry. Each cycle: out_sum[8*idx +: 8] <= add_sum, carry <= add_cout, idx <= idx+1.
- RUN, idx = NBYTES-1: additionally out_cout <= add_cout; out_ovf <= (a_reg[W-1] == b_eff[W-1]) && (add_sum[7] != a_reg[W-1]); go DONE.
- Outside RUN: add_a=0, add_b=0, add_cin=0. add_sum/add_cout are ignored.
- DONE: hold out_sum/out_cout/out_ovf stable while out_valid=1 and out_ready=0. On out_ready go IDLE; result registers retain their values, and out_valid drops the next cycle.
- in_ready=0 during RUN and DONE: no overlap and no IDLE bypass.
- Latency: request accepted at edge T; RUN occupies cycles T+1..T+NBYTES; out_valid rises after edge T+NBYTES. Minimum initiation interval is NBYTES+2 cycles when out_ready is tied high.
- Width rules: idx is clog2(NBYTES) bits, minimum 1. With NBYTES=1, RUN lasts exactly one cycle. Carry propagates only through registered carry; no combinational path from add_cout to add_cin.
- Result equals (A + B_eff + carry0) mod 2^W; cout is bit W of the unbounded sum.

Test Plan:
- NBYTES=4, A=0x000000FF, B=0x00000001, cin=0, add -> out_sum=0x00000100, cout=0, ovf=0; out_valid exactly 5 cycles after the accept edge; add_cin=1 on the second RUN cycle.
- A=0xFFFFFFFF, B=0x00000000, cin=1, add -> out_sum=0x00000000, cout=1, ovf=0; carry ripples through all 4 bytes.
- Subtract A=0x00000005, B=0x00000007 (in_cin=1 ignored) -> out_sum=0xFFFFFFFE, cout=0, ovf=0. Subtract A=0x80000000, B=1 -> out_sum=0x7FFFFFFF, cout=1, ovf=1.
- Add A=0x7FFFFFFF, B=0x00000001, cin=0 -> out_sum=0x80000000, cout=0, ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid held, outputs stable, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE next cycle, and the next request is accepted.
- Reset asserted during RUN at idx=2 -> next cycle IDLE, out_valid=0, outputs 0, add_* driven 0. A new request afterwards produces a correct result with no stale carry. Repeat all cases with NBYTES=1: 0xFF+0x01 -> sum=0x00, cout=1.

Source files
------------

// File: rtl/adder_byte_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_byte_sequencer_if
// Description : Operand request / result handshake bundle for the byte
//               sequencer. "slave" is the sequencer side, "master" the peer.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_byte_sequencer_if #(
    parameter int NBYTES = 4
) ();
    localparam int c_W = 8 * NBYTES;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_a;
    logic [c_W-1:0] in_b;
    logic           in_cin;
    logic           in_sub;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_sum;
    logic           out_cout;
    logic           out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/adder_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adder_byte_sequencer
// Description : Runs an NBYTES-wide add/subtract through one external 8-bit
//               adder, one byte per cycle, LSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    adder_byte_sequencer_if.slave        bus,
    output logic [7:0]                   add_a,
    output logic [7:0]                   add_b,
    output logic                         add_cin,
    input  logic [7:0]                   add_sum,
    input  logic                         add_cout
);
    localparam int c_IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDXW-1:0]       r_idx;
    logic                    r_carry;
    logic [NBYTES-1:0][7:0]  r_a;
    logic [NBYTES-1:0][7:0]  r_b;
    logic [NBYTES-1:0][7:0]  r_sum;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    w_last;

    assign w_last = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The adder pins carry only registered values, so the carry chain is
    // broken by r_carry between bytes.
    always_comb begin
        w_state_nxt = r_state;
        add_a       = 8'h00;
        add_b       = 8'h00;
        add_cin     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = r_a[r_idx];
                add_b   = r_b[r_idx];
                add_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx] <= add_sum;
                    r_carry      <= add_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= add_cout;
                        // Overflow: like-signed operands yielding an unlike-signed result.
                        r_ovf  <= (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) &&
                                  (add_sum[7] != r_a[NBYTES-1][7]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_byte_sequencer
// Description : Directed self-checking bench for NBYTES=4 and NBYTES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_byte_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_byte_sequencer_if #(.NBYTES(4)) bus4 ();
    adder_byte_sequencer_if #(.NBYTES(1)) bus1 ();

    logic [7:0] add_a4, add_b4, add_sum4;
    logic       add_cin4, add_cout4;
    logic [7:0] add_a1, add_b1, add_sum1;
    logic       add_cin1, add_cout1;

    // External shared 8-bit adders
    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {8'h00, add_cin4};
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'h00, add_cin1};

    adder_byte_sequencer #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    adder_byte_sequencer #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    logic last_cin2;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub,
                       input logic [31:0] esum, input logic ecout, input logic eovf);
        int cnt;
        @(negedge clk);
        check_value({tag, " in_ready"}, 32'(bus4.in_ready), 32'd1);
        bus4.in_a     = a;
        bus4.in_b     = b;
        bus4.in_cin   = cin;
        bus4.in_sub   = sub;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        cnt       = 0;
        last_cin2 = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) bus4.in_valid = 1'b0;
            if (cnt == 2) last_cin2 = add_cin4;
        end while (!bus4.out_valid && cnt < 40);
        check_value({tag, " latency"}, 32'(cnt), 32'd5);
        check_value({tag, " sum"}, bus4.out_sum, esum);
        check_value({tag, " cout"}, 32'(bus4.out_cout), 32'(ecout));
        check_value({tag, " ovf"}, 32'(bus4.out_ovf), 32'(eovf));
    endtask

    task automatic release4(input string tag);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        check_value({tag, " valid drop"}, 32'(bus4.out_valid), 32'd0);
        check_value({tag, " back idle"}, 32'(bus4.in_ready), 32'd1);
    endtask

    task automatic op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub,
                       input logic [7:0] esum, input logic ecout, input logic eovf);
        int cnt;
        @(negedge clk);
        check_value({tag, " in_ready"}, 32'(bus1.in_ready), 32'd1);
        bus1.in_a     = a;
        bus1.in_b     = b;
        bus1.in_cin   = cin;
        bus1.in_sub   = sub;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) bus1.in_valid = 1'b0;
        end while (!bus1.out_valid && cnt < 40);
        check_value({tag, " latency"}, 32'(cnt), 32'd2);
        check_value({tag, " sum"}, 32'(bus1.out_sum), 32'(esum));
        check_value({tag, " cout"}, 32'(bus1.out_cout), 32'(ecout));
        check_value({tag, " ovf"}, 32'(bus1.out_ovf), 32'(eovf));
        @(negedge clk);
        check_value({tag, " valid drop"}, 32'(bus1.out_valid), 32'd0);
    endtask

    initial begin
        int   hold_ok;
        logic [31:0] held_sum;

        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
        bus4.in_sub = 1'b0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
        bus1.in_sub = 1'b0; bus1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("reset in_ready", 32'(bus4.in_ready), 32'd1);
        check_value("reset out_valid", 32'(bus4.out_valid), 32'd0);
        check_value("reset sum", bus4.out_sum, 32'd0);
        check_value("reset add_a", 32'(add_a4), 32'd0);

        op4("add ff+1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        check_value("add ff+1 cin byte1", 32'(last_cin2), 32'd1);
        release4("add ff+1");
        op4("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        release4("ripple");
        op4("sub 5-7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        release4("sub 5-7");
        op4("sub min-1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        release4("sub min-1");
        op4("add max+1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        release4("add max+1");

        // Reset while RUN is on byte 2, carry set into that byte
        @(negedge clk);
        bus4.in_a = 32'h11EE_FFFF; bus4.in_b = 32'h0; bus4.in_cin = 1'b1;
        bus4.in_sub = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_value("mid idx2 add_a", 32'(add_a4), 32'h0000_00EE);
        check_value("mid idx2 add_cin", 32'(add_cin4), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value("mid rst in_ready", 32'(bus4.in_ready), 32'd1);
        check_value("mid rst out_valid", 32'(bus4.out_valid), 32'd0);
        check_value("mid rst sum", bus4.out_sum, 32'd0);
        check_value("mid rst cout", 32'(bus4.out_cout), 32'd0);
        check_value("mid rst ovf", 32'(bus4.out_ovf), 32'd0);
        check_value("mid rst add_pins", {15'd0, add_a4, add_b4, add_cin4}, 32'd0);
        op4("post rst 1+1", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        release4("post rst");

        // Backpressure: result held for 10 cycles, new requests refused
        bus4.out_ready = 1'b0;
        op4("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        held_sum = bus4.out_sum;
        hold_ok  = 0;
        bus4.in_a = 32'hDEAD_BEEF; bus4.in_b = 32'h0BAD_F00D; bus4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.out_valid && !bus4.in_ready && bus4.out_sum == held_sum &&
                !bus4.out_cout && !bus4.out_ovf)
                hold_ok++;
        end
        check_value("bp hold cycles", 32'(hold_ok), 32'd10);
        bus4.in_valid = 1'b0;
        release4("bp");
        op4("after bp", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        release4("after bp");

        op1("n1 ff+1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op1("n1 sub 80-1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op1("n1 7f+1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op1("n1 sub 5-7", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
